// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core's PC sequencing logic.
package mips_pkg;

  // Sequencer states: fetch, wait for decode, wait for the ALU zero flag, commit.
  typedef enum logic [1:0] {
    BUSCA    = 2'd0,
    DECIDE   = 2'd1,
    AVALIA   = 2'd2,
    ATUALIZA = 2'd3
  } estado_t;

  localparam logic [31:0] RESET_PC_PADRAO = 32'h0000_0000;

  // Branch offset in words -> signed byte offset.
  function automatic logic [31:0] desloc_desvio(input logic [15:0] imediato);
    return {{14{imediato[15]}}, imediato, 2'b00};
  endfunction

endpackage

// File: rtl/somador_branch.sv
// Branch adder of the core: pc_mais4 plus the byte offset gives the branch target.
module somador_branch (
  input  logic [31:0] base,
  input  logic [31:0] desloc,
  output logic [31:0] soma
);

  assign soma = base + desloc;

endmodule

// File: rtl/controle_pc.sv
// Multicycle next-PC sequencer: fetch over req/ack, wait for the decoder decision,
// wait for the ALU zero flag on branches, then commit PC+4, branch or jump target.
//
// Handshakes: mem_req is held high in BUSCA until the cycle mem_ack is seen
// (mem_dado valid in that same cycle); decisao_valida and zero_valido are single
// sampled qualifiers, acted upon only in DECIDE and AVALIA respectively and ignored
// in every other state.
module controle_pc #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC_PADRAO,
  parameter int          LARGURA  = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               mem_req,
  output logic [LARGURA-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [LARGURA-1:0] mem_dado,
  output logic [LARGURA-1:0] instrucao,
  output logic               instrucao_valida,
  input  logic               decisao_valida,
  input  logic               salto,
  input  logic               desvio_eq,
  input  logic               desvio_ne,
  input  logic [15:0]        imediato,
  input  logic [25:0]        alvo,
  input  logic               zero,
  input  logic               zero_valido,
  input  logic               congela,
  output logic [LARGURA-1:0] pc,
  output logic [31:0]        contador_instr,
  output logic [1:0]         estado
);

  import mips_pkg::*;

  estado_t            estado_atual, estado_prox;
  logic               reset_reg;
  logic [LARGURA-1:0] pc_mais4;
  logic [LARGURA-1:0] prox;
  logic [15:0]        imediato_reg;
  logic               eq_reg, ne_reg;
  logic [LARGURA-1:0] alvo_desvio;
  logic               tomado;
  logic               aceita_busca, aceita_decisao, aceita_zero, commit;

  assign estado   = estado_atual;
  assign mem_addr = pc;
  assign mem_req  = (estado_atual == BUSCA) && !reset_reg;
  assign tomado   = (eq_reg & zero) | (ne_reg & ~zero);

  somador_branch u_somador_branch (
    .base   (pc_mais4),
    .desloc (desloc_desvio(imediato_reg)),
    .soma   (alvo_desvio)
  );

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clock) begin
    if (reset) estado_atual <= BUSCA;
    else       estado_atual <= estado_prox;
  end

  // Next-state logic and the per-state accept strobes that enable the datapath.
  always_comb begin
    estado_prox    = estado_atual;
    aceita_busca   = 1'b0;
    aceita_decisao = 1'b0;
    aceita_zero    = 1'b0;
    commit         = 1'b0;
    case (estado_atual)
      BUSCA: begin
        if (mem_req && mem_ack) begin
          aceita_busca = 1'b1;
          estado_prox  = DECIDE;
        end
      end
      DECIDE: begin
        if (decisao_valida) begin
          aceita_decisao = 1'b1;
          if (!salto && (desvio_eq || desvio_ne)) estado_prox = AVALIA;
          else                                    estado_prox = ATUALIZA;
        end
      end
      AVALIA: begin
        if (zero_valido) begin
          aceita_zero = 1'b1;
          estado_prox = ATUALIZA;
        end
      end
      ATUALIZA: begin
        if (!congela) begin
          commit      = 1'b1;
          estado_prox = BUSCA;
        end
      end
      default: estado_prox = BUSCA;
    endcase
  end

  // One-cycle flag after reset keeps mem_req low in the first released cycle.
  always_ff @(posedge clock) begin
    reset_reg <= reset;
  end

  // Datapath: instruction latch, PC+4, latched branch operands, next PC and commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc               <= RESET_PC;
      instrucao        <= '0;
      instrucao_valida <= 1'b0;
      contador_instr   <= '0;
      pc_mais4         <= '0;
      prox             <= '0;
      imediato_reg     <= '0;
      eq_reg           <= 1'b0;
      ne_reg           <= 1'b0;
    end else begin
      instrucao_valida <= aceita_busca;
      if (aceita_busca) begin
        instrucao <= mem_dado;
        pc_mais4  <= pc + LARGURA'(4);
      end
      if (aceita_decisao) begin
        if (salto) begin
          prox <= {pc_mais4[31:28], alvo, 2'b00};
        end else if (desvio_eq || desvio_ne) begin
          imediato_reg <= imediato;
          eq_reg       <= desvio_eq;
          ne_reg       <= desvio_ne;
        end else begin
          prox <= pc_mais4;
        end
      end
      if (aceita_zero) begin
        prox <= tomado ? alvo_desvio : pc_mais4;
      end
      if (commit) begin
        pc             <= prox;
        contador_instr <= contador_instr + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_controle_pc.sv
// Testbench for controle_pc: directed scenarios plus randomized instruction stream,
// checked against a behavioural next-PC model.
module tb_controle_pc;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_dado;
  logic [31:0] instrucao;
  logic        instrucao_valida;
  logic        decisao_valida;
  logic        salto, desvio_eq, desvio_ne;
  logic [15:0] imediato;
  logic [25:0] alvo;
  logic        zero, zero_valido, congela;
  logic [31:0] pc;
  logic [31:0] contador_instr;
  logic [1:0]  estado;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] exp_q[$];

  controle_pc #(.RESET_PC(32'h0000_0000), .LARGURA(32)) dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_dado(mem_dado), .instrucao(instrucao),
    .instrucao_valida(instrucao_valida), .decisao_valida(decisao_valida),
    .salto(salto), .desvio_eq(desvio_eq), .desvio_ne(desvio_ne),
    .imediato(imediato), .alvo(alvo), .zero(zero), .zero_valido(zero_valido),
    .congela(congela), .pc(pc), .contador_instr(contador_instr), .estado(estado)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference model: next PC from the architectural rules, plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic s, eq, ne,
                                           input logic [15:0] imm, input logic [25:0] al,
                                           input logic z);
    logic [31:0] seq;
    int          off_bytes;
    seq = cur + 32'd4;
    if (s) return (seq & 32'hF000_0000) | (32'(al) * 32'd4);
    if ((eq && z) || (ne && !z)) begin
      off_bytes = $signed(imm) * 4;
      return seq + 32'(off_bytes);
    end
    return seq;
  endfunction

  // Drives one complete instruction through the handshakes and checks the commit.
  task automatic do_instr(input logic s, eq, ne, input logic [15:0] imm,
                          input logic [25:0] al, input logic z,
                          input int ack_d, dec_d, z_d, cong_d, output int ciclos);
    logic [31:0] pc0, exp_pc, dado;
    logic        ramo;
    int          c0, w, exp_ciclos;
    pc0    = m_pc;
    exp_pc = ref_next(m_pc, s, eq, ne, imm, al, z);
    ramo   = !s && (eq || ne);
    exp_q.push_back(exp_pc);
    ciclos = 0;
    w = 0;
    while (!mem_req && w < 20) begin tick; w++; end
    checks++;
    if (!mem_req) begin
      failures++;
      $display("FAIL fetch_timeout: mem_req=%b required 1 within 20 cycles", mem_req);
      return;
    end
    c0 = cyc;
    checks++;
    if (mem_addr !== pc0) begin
      failures++; $display("FAIL mem_addr: got %h required %h", mem_addr, pc0);
    end
    for (int i = 0; i < ack_d; i++) begin
      decisao_valida = 1'($urandom_range(0, 1));
      zero_valido    = 1'($urandom_range(0, 1));
      tick;
    end
    decisao_valida = 1'b0;
    zero_valido    = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL mem_req_hold: got %b required 1", mem_req);
    end
    dado = $urandom; mem_ack = 1'b1; mem_dado = dado;
    tick;
    mem_ack = 1'b0; mem_dado = $urandom;
    checks++;
    if (instrucao_valida !== 1'b1 || instrucao !== dado) begin
      failures++;
      $display("FAIL instr_latch: got valid=%b instr=%h required valid=1 instr=%h",
               instrucao_valida, instrucao, dado);
    end
    for (int i = 0; i < dec_d; i++) begin
      mem_ack     = 1'($urandom_range(0, 1));
      zero_valido = 1'($urandom_range(0, 1));
      tick;
    end
    mem_ack = 1'b0; zero_valido = 1'b0;
    if (dec_d > 0) begin
      checks++;
      if (instrucao_valida !== 1'b0) begin
        failures++; $display("FAIL valid_pulse: got %b required 0", instrucao_valida);
      end
    end
    decisao_valida = 1'b1; salto = s; desvio_eq = eq; desvio_ne = ne;
    imediato = imm; alvo = al;
    tick;
    decisao_valida = 1'b0;
    salto = 1'($urandom_range(0, 1)); desvio_eq = 1'($urandom_range(0, 1));
    desvio_ne = 1'($urandom_range(0, 1));
    imediato = 16'($urandom); alvo = 26'($urandom);
    if (ramo) begin
      for (int i = 0; i < z_d; i++) begin
        decisao_valida = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        tick;
      end
      decisao_valida = 1'b0; zero = z; zero_valido = 1'b1;
      tick;
      zero_valido = 1'b0; zero = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < cong_d; i++) begin
      congela = 1'b1;
      tick;
      checks++;
      if (pc !== pc0) begin
        failures++; $display("FAIL congela_hold: got pc=%h required %h", pc, pc0);
      end
    end
    congela = 1'b0;
    tick;
    ciclos = cyc - c0;
    exp_ciclos = (ack_d + 1) + (dec_d + 1) + (ramo ? z_d + 1 : 0) + (cong_d + 1);
    m_pc  = exp_q.pop_front();
    m_cnt = m_cnt + 32'd1;
    checks++;
    if (pc !== m_pc || contador_instr !== m_cnt) begin
      failures++;
      $display("FAIL commit: got pc=%h cnt=%0d required pc=%h cnt=%0d",
               pc, contador_instr, m_pc, m_cnt);
    end
    checks++;
    if (ciclos != exp_ciclos) begin
      failures++; $display("FAIL latency: got %0d cycles required %0d", ciclos, exp_ciclos);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    m_pc = 32'h0; m_cnt = 32'h0;
    checks++;
    if (pc !== 32'h0 || contador_instr !== 32'h0 || mem_req !== 1'b0 ||
        instrucao !== 32'h0 || instrucao_valida !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got pc=%h cnt=%0d req=%b instr=%h valid=%b required 0,0,0,0,0",
               pc, contador_instr, mem_req, instrucao, instrucao_valida);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL reset_req_rise: got %b required 1", mem_req);
    end
  endtask

  task automatic test_sequential;
    int c;
    do_instr(0, 0, 0, 16'h0, 26'h0, 0, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'h4 || c != 3) begin
      failures++; $display("FAIL seq_step1: got pc=%h cycles=%0d required 4, 3", pc, c);
    end
    do_instr(0, 0, 0, 16'h0, 26'h0, 0, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'h8 || contador_instr !== 32'd2 || c != 3) begin
      failures++;
      $display("FAIL seq_step2: got pc=%h cnt=%0d cycles=%0d required 8, 2, 3",
               pc, contador_instr, c);
    end
  endtask

  task automatic test_wrap_and_congela;
    int c;
    do_instr(0, 1, 0, 16'hFFFC, 26'h0, 1, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL neg_wrap: got %h required fffffffc", pc);
    end
    do_instr(0, 0, 0, 16'h0, 26'h0, 0, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL seq_wrap: got %h required 00000000", pc);
    end
    do_instr(0, 0, 0, 16'h0, 26'h0, 0, 1, 0, 0, 4, c);
    checks++;
    if (pc !== 32'h4 || c != 8) begin
      failures++; $display("FAIL congela_commit: got pc=%h cycles=%0d required 4, 8", pc, c);
    end
  endtask

  task automatic test_branches;
    int c;
    do_instr(1, 0, 0, 16'h0, 26'h4, 0, 0, 0, 0, 0, c);
    do_instr(0, 1, 0, 16'hFFFC, 26'h0, 1, 0, 1, 2, 0, c);
    checks++;
    if (pc !== 32'h4) begin
      failures++; $display("FAIL beq_taken: got %h required 00000004", pc);
    end
    do_instr(1, 0, 0, 16'h0, 26'h8, 0, 0, 0, 0, 0, c);
    do_instr(0, 0, 1, 16'h0040, 26'h0, 1, 0, 0, 1, 0, c);
    checks++;
    if (pc !== 32'h24) begin
      failures++; $display("FAIL bne_not_taken: got %h required 00000024", pc);
    end
    do_instr(0, 1, 1, 16'h0002, 26'h0, 1, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'h30) begin
      failures++; $display("FAIL eq_ne_taken: got %h required 00000030", pc);
    end
  endtask

  task automatic test_jump_priority;
    int c;
    for (int k = 0; k < 3; k++) begin
      do_instr(1, 0, 0, 16'h0, 26'h3FF_FFFF, 0, 0, 0, 0, 0, c);
      do_instr(0, 0, 0, 16'h0, 26'h0, 0, 0, 0, 0, 0, c);
    end
    checks++;
    if (pc !== 32'h3000_0000) begin
      failures++; $display("FAIL region_walk: got %h required 30000000", pc);
    end
    do_instr(1, 1, 0, 16'hFFFF, 26'h000_0040, 1, 0, 0, 0, 0, c);
    checks++;
    if (pc !== 32'h3000_0100) begin
      failures++; $display("FAIL salto_priority: got %h required 30000100", pc);
    end
  endtask

  task automatic test_random;
    int          c;
    logic        s, eq, ne, z;
    for (int n = 0; n < 24; n++) begin
      s  = ($urandom_range(0, 3) == 0);
      eq = 1'($urandom_range(0, 1));
      ne = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      do_instr(s, eq, ne, 16'($urandom), 26'($urandom), z,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2), c);
    end
  endtask

  task automatic test_reset_in_avalia;
    int w;
    w = 0;
    while (!mem_req && w < 20) begin tick; w++; end
    mem_ack = 1'b1; mem_dado = $urandom;
    tick;
    mem_ack = 1'b0;
    decisao_valida = 1'b1; salto = 1'b0; desvio_eq = 1'b1; desvio_ne = 1'b0;
    imediato = 16'h0010;
    tick;
    decisao_valida = 1'b0;
    tick;
    checks++;
    if (estado !== 2'd2) begin
      failures++; $display("FAIL avalia_reached: got state %0d required 2", estado);
    end
    reset = 1'b1; zero = 1'b1; zero_valido = 1'b1;
    tick;
    reset = 1'b0; zero_valido = 1'b0;
    m_pc = 32'h0; m_cnt = 32'h0;
    tick;
    checks++;
    if (pc !== 32'h0 || contador_instr !== 32'h0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_abort: got pc=%h cnt=%0d req=%b required 0, 0, 1",
               pc, contador_instr, mem_req);
    end
  endtask

  // Test sequence and final report
  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_dado = '0; decisao_valida = 1'b0;
    salto = 1'b0; desvio_eq = 1'b0; desvio_ne = 1'b0; imediato = '0; alvo = '0;
    zero = 1'b0; zero_valido = 1'b0; congela = 1'b0;
    m_pc = '0; m_cnt = '0;
    test_reset;
    test_sequential;
    test_wrap_and_congela;
    test_branches;
    test_jump_priority;
    test_random;
    test_reset_in_avalia;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
